mms_ptw: RTL and testbench
==========================

Name: mms_ptw

Overview:
Sv32 hardware page-table walker. It sits directly upstream of the TLB and ITLB and services one miss at a time. The walker reads up to two PTEs through a single-outstanding memory read port. It then either emits a one-cycle refill (VPN, PPN, flags, level, ASID) into the TLB or signals a page fault. Accessed/dirty bits are never updated in hardware; A=0 is reported as a fault.

Parameters:
PADDR_WD, 34, physical address width
VADDR_WD, 32, virtual address width
PPN_WD, 22, physical page number width (PPN1 12 + PPN0 10)
ASID_WD, 9, address-space ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_valid  in  1  TLB miss request
miss_ready  out  1  walker idle, request accepted when valid&ready
miss_vaddr  in  VADDR_WD  faulting virtual address (VPN1=[31:22], VPN0=[21:12])
miss_asid  in  ASID_WD  ASID tagged onto refill
satp_ppn  in  PPN_WD  root page-table PPN, sampled at accept
flush  in  1  sfence/satp change; abort walk, no refill
mem_req_valid  out  1  PTE read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  PADDR_WD  PTE physical address
mem_rsp_valid  in  1  PTE data valid (exactly one per accepted request)
mem_rsp_data  in  32  PTE
refill_valid  out  1  one-cycle refill pulse; TLB always accepts
refill_vpn  out  20  {VPN1,VPN0}
refill_ppn  out  PPN_WD  leaf PTE PPN[31:10], unmodified
refill_flags  out  8  leaf PTE[7:0] (V R W X U G A D)
refill_level  out  1  1 = 4 MiB superpage, 0 = 4 KiB page
refill_asid  out  ASID_WD  latched ASID
fault_valid  out  1  one-cycle page-fault pulse
fault_vaddr  out  VADDR_WD  latched faulting address

Behaviour:
- FSM states: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT, DRAIN.
- Reset (sync, any state): state=IDLE; miss_ready=1; mem_req_valid, refill_valid, fault_valid=0; all latched address/data registers=0.
- IDLE: miss_ready=1. On miss_valid, latch vaddr, asid and satp_ppn, then go to L1_REQ. If flush is high in the same cycle, the request is still accepted; flush affects only walks already in progress.
- L1_REQ: mem_req_valid=1, mem_req_addr = {satp_ppn,12'b0} + {VPN1,2'b0}, computed at 34 bits with no truncation. Hold address stable until mem_req_ready, then go to L1_WAIT.
- L1_WAIT: on mem_rsp_valid, decode the PTE:
  - V=0, or R=0&W=1 -> FAULT.
  - Leaf (R|X): fault if PPN[9:0]!=0 (misaligned superpage) or A=0; otherwise -> DONE with level=1.
  - Non-leaf (R=X=W=0) -> L0_REQ, next base = PTE[31:10].
- L0_REQ: addr = {PTE_ppn,12'b0} + {VPN0,2'b0}, same handshake as L1_REQ -> L0_WAIT.
- L0_WAIT: on response:
  - V=0, R=0&W=1, non-leaf, or A=0 -> FAULT.
  - Otherwise -> DONE with level=0.
- DONE: refill_valid=1 for exactly one cycle, refill_* driven from latched values -> IDLE. No refill fields change while refill_valid=1.
- FAULT: fault_valid=1 for one cycle -> IDLE. refill_valid and fault_valid are never high together.
- Flush handling:
  - In L1_REQ/L0_REQ before the handshake: go straight to IDLE. mem_req_valid drops the next cycle.
  - In L1_REQ/L0_REQ with mem_req_ready in the same cycle, or in L1_WAIT/L0_WAIT without mem_rsp_valid: go to DRAIN.
  - In L1_WAIT/L0_WAIT with mem_rsp_valid in the same cycle: discard the PTE -> IDLE.
  - In DONE/FAULT: the pulse still fires; the TLB flush takes priority downstream.
- DRAIN: miss_ready=0; wait for mem_rsp_valid, discard the data -> IDLE. Further flushes are ignored.
- mem_rsp_valid outside *_WAIT/DRAIN is ignored. At most one memory request is outstanding.
- Minimum latency with a zero-wait memory (ready=1, response the cycle after accept):
  - Accept at cycle 0; L1 request at cycle 1; response at cycle 2; L0 request at cycle 3; response at cycle 4; refill_valid at cycle 5.
  - Superpage: refill_valid at cycle 3.

Test Plan:
- 4 KiB walk:
  - Stimulus: satp_ppn=22'h00080, vaddr=32'h0040_3123, asid=9'h005.
  - L1 request addr 34'h0_0008_0004; return 32'h0002_4001.
  - L0 request addr 34'h0_0009_000C; return 32'h048D_14C7.
  - Required: refill_valid 1 cycle, vpn=20'h00403, ppn=22'h12345, flags=8'hC7, level=0, asid=9'h005, at cycle 5.
- Superpage: same request, L1 returns 32'h0010_0049 -> refill ppn=22'h00400, flags=8'h49, level=1 at cycle 3, no second memory request.
- Faults:
  - L1 returns 32'h0010_0449 (misaligned) -> fault_valid, fault_vaddr=32'h0040_3123.
  - L1 returns 32'h0000_0000 -> fault.
  - L0 returns 32'h048D_1487 (A=0) -> fault.
  - All cases: no refill.
- Back-pressure: mem_req_ready held low 4 cycles -> mem_req_addr stable and mem_req_valid held high; refill is delayed by exactly 4 cycles; miss_ready=0 throughout.
- Flush in L0_WAIT:
  - Response arrives 3 cycles later -> no refill, no fault, miss_ready=0 until the cycle after the response.
  - A new miss is then accepted normally.
- Reset mid-walk: rst in L1_WAIT -> next cycle state IDLE, miss_ready=1, all pulses 0; a stale mem_rsp_valid after reset causes no output.

Source files
------------

// File: rtl/mms_ptw.sv
// mms_ptw: Sv32 two-level page-table walker feeding TLB refills or page faults
module mms_ptw #(
  parameter int PADDR_WD = 34,
  parameter int VADDR_WD = 32,
  parameter int PPN_WD   = 22,
  parameter int ASID_WD  = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [VADDR_WD-1:0] miss_vaddr,
  input  logic [ASID_WD-1:0]  miss_asid,
  input  logic [PPN_WD-1:0]   satp_ppn,
  input  logic                flush,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [PADDR_WD-1:0] mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rsp_data,
  output logic                refill_valid,
  output logic [19:0]         refill_vpn,
  output logic [PPN_WD-1:0]   refill_ppn,
  output logic [7:0]          refill_flags,
  output logic                refill_level,
  output logic [ASID_WD-1:0]  refill_asid,
  output logic                fault_valid,
  output logic [VADDR_WD-1:0] fault_vaddr
);
  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [VADDR_WD-1:0] vaddr_q, vaddr_d;
  logic [ASID_WD-1:0] asid_q, asid_d;
  logic [PADDR_WD-1:0] addr_q, addr_d;
  logic [PPN_WD-1:0] ppn_q, ppn_d;
  logic [7:0] flags_q, flags_d;
  logic level_q, level_d;
  logic miss_ready_q, miss_ready_d;
  logic req_valid_q, req_valid_d;
  logic refill_q, refill_d;
  logic fault_q, fault_d;
  logic pte_bad, pte_leaf, pte_a, rsw_unused;
  assign pte_bad = !mem_rsp_data[0] || (!mem_rsp_data[1] && mem_rsp_data[2]);
  assign pte_leaf = mem_rsp_data[1] | mem_rsp_data[3];
  assign pte_a = mem_rsp_data[6];
  assign rsw_unused = ^mem_rsp_data[9:8];
  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    asid_d = asid_q;
    addr_d = addr_q;
    ppn_d = ppn_q;
    flags_d = flags_q;
    level_d = level_q;
    case (state_q)
      IDLE:
        if (miss_valid) begin
          state_d = L1_REQ;
          vaddr_d = miss_vaddr;
          asid_d = miss_asid;
          addr_d = PADDR_WD'({satp_ppn, 12'b0}) + PADDR_WD'({miss_vaddr[31:22], 2'b0});
        end
      L1_REQ, L0_REQ:
        if (flush) state_d = mem_req_ready ? DRAIN : IDLE;
        else if (mem_req_ready) state_d = state_q == L1_REQ ? L1_WAIT : L0_WAIT;
      L1_WAIT:
        if (mem_rsp_valid) begin
          ppn_d = mem_rsp_data[31:10];
          flags_d = mem_rsp_data[7:0];
          level_d = 1'b1;
          addr_d = PADDR_WD'({mem_rsp_data[31:10], 12'b0}) + PADDR_WD'({vaddr_q[21:12], 2'b0});
          state_d = flush ? IDLE : pte_bad ? FAULT : !pte_leaf ? L0_REQ :
                    (mem_rsp_data[19:10] != 10'd0 || !pte_a) ? FAULT : DONE;
        end else if (flush) state_d = DRAIN;
      L0_WAIT:
        if (mem_rsp_valid) begin
          ppn_d = mem_rsp_data[31:10];
          flags_d = mem_rsp_data[7:0];
          level_d = 1'b0;
          state_d = flush ? IDLE : (pte_bad || !pte_leaf || !pte_a) ? FAULT : DONE;
        end else if (flush) state_d = DRAIN;
      DONE, FAULT: state_d = IDLE;
      DRAIN: if (mem_rsp_valid) state_d = IDLE;
    endcase
    miss_ready_d = state_d == IDLE;
    req_valid_d = state_d == L1_REQ || state_d == L0_REQ;
    refill_d = state_d == DONE;
    fault_d = state_d == FAULT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vaddr_q <= '0;
      asid_q <= '0;
      addr_q <= '0;
      ppn_q <= '0;
      flags_q <= '0;
      level_q <= 1'b0;
      miss_ready_q <= 1'b1;
      req_valid_q <= 1'b0;
      refill_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      asid_q <= asid_d;
      addr_q <= addr_d;
      ppn_q <= ppn_d;
      flags_q <= flags_d;
      level_q <= level_d;
      miss_ready_q <= miss_ready_d;
      req_valid_q <= req_valid_d;
      refill_q <= refill_d;
      fault_q <= fault_d;
    end
  end
  assign miss_ready = miss_ready_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr = addr_q;
  assign refill_valid = refill_q;
  assign refill_vpn = vaddr_q[31:12];
  assign refill_ppn = ppn_q;
  assign refill_flags = flags_q;
  assign refill_level = level_q;
  assign refill_asid = asid_q;
  assign fault_valid = fault_q;
  assign fault_vaddr = vaddr_q;
endmodule

// File: tb/tb_mms_ptw.sv
// tb_mms_ptw: directed walks against a cycle-level Sv32 walk model with per-cycle output checks
module tb_mms_ptw;
  logic clk = 0, rst = 1;
  logic miss_valid = 0, flush = 0, mem_req_ready = 0, mem_rsp_valid = 0;
  logic [31:0] miss_vaddr = 0, mem_rsp_data = 0;
  logic [8:0] miss_asid = 0;
  logic [21:0] satp_ppn = 0;
  logic miss_ready, mem_req_valid, refill_valid, refill_level, fault_valid;
  logic [33:0] mem_req_addr;
  logic [19:0] refill_vpn;
  logic [21:0] refill_ppn;
  logic [7:0] refill_flags;
  logic [8:0] refill_asid;
  logic [31:0] fault_vaddr;

  mms_ptw dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_vaddr(miss_vaddr), .miss_asid(miss_asid), .satp_ppn(satp_ppn), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .refill_valid(refill_valid), .refill_vpn(refill_vpn), .refill_ppn(refill_ppn),
    .refill_flags(refill_flags), .refill_level(refill_level), .refill_asid(refill_asid),
    .fault_valid(fault_valid), .fault_vaddr(fault_vaddr)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] pte_tab[2];
  int rd_tab[2], rs_tab[2];
  int m_kind, m_nreq, m_tend, m_fl;
  int m_s[2];
  logic [33:0] m_addr[2];
  logic [21:0] m_ppn;
  logic [7:0] m_flags;
  logic m_level;
  logic [31:0] m_vaddr;
  logic [8:0] m_asid;

  function automatic int classify(input logic [31:0] p, input int lvl);
    if (!p[0] || (!p[1] && p[2])) return 2;
    if (!p[1] && !p[3]) return lvl == 1 ? 0 : 2;
    if (!p[6]) return 2;
    if (lvl == 1 && (p >> 10) % 1024 != 0) return 2;
    return 1;
  endfunction

  task automatic model(input logic [21:0] satp, input logic [31:0] va, input int mode);
    int t, c, lvl;
    logic [31:0] p;
    m_kind = 0;
    m_nreq = 1;
    m_fl = -1;
    m_s[0] = 1;
    m_s[1] = -100;
    m_addr[0] = 34'(longint'(satp) * 4096 + longint'(va >> 22) * 4);
    m_addr[1] = 0;
    t = m_s[0] + rd_tab[0] + rs_tab[0];
    if (mode == 2) begin
      m_tend = m_s[0] + rd_tab[0] + 1;
      return;
    end
    c = classify(pte_tab[0], 1);
    lvl = 1;
    p = pte_tab[0];
    if (c == 0) begin
      m_nreq = 2;
      m_s[1] = t + 1;
      m_addr[1] = 34'(longint'(pte_tab[0] >> 10) * 4096 + longint'((va >> 12) % 1024) * 4);
      t = m_s[1] + rd_tab[1] + rs_tab[1];
      if (mode == 1) begin
        m_fl = m_s[1] + rd_tab[1] + 1;
        m_tend = t;
        return;
      end
      c = classify(pte_tab[1], 0);
      lvl = 0;
      p = pte_tab[1];
    end
    m_tend = t + 1;
    m_kind = c == 1 ? 1 : 2;
    m_ppn = 22'(p >> 10);
    m_flags = p[7:0];
    m_level = lvl == 1;
  endtask

  int ri = 0, wc = 0, pc = 0, pi = 0;
  bit pend = 0;
  initial forever begin
    @(negedge clk);
    mem_rsp_valid = 0;
    if (mem_req_ready) begin
      pend = 1;
      pi = ri;
      pc = rs_tab[ri];
      ri = 1;
      wc = 0;
    end
    if (pend) begin
      pc--;
      if (pc <= 0) begin
        mem_rsp_valid = 1;
        mem_rsp_data = pte_tab[pi];
        pend = 0;
      end
    end
    mem_req_ready = mem_req_valid && wc >= rd_tab[ri];
    if (mem_req_valid && !mem_req_ready) wc++;
  end

  bit active = 0;
  int t0, rel, c_rel, n_ref, n_flt;
  bit exp_rv;
  logic [21:0] c_ppn;
  logic [7:0] c_flags;
  logic c_level;
  logic [19:0] c_vpn;
  logic [8:0] c_asid;
  logic [31:0] c_fva;
  initial forever begin
    @(negedge clk);
    if (active) begin
      rel = cyc - t0;
      exp_rv = (rel >= m_s[0] && rel <= m_s[0] + rd_tab[0]) ||
               (m_nreq == 2 && rel >= m_s[1] && rel <= m_s[1] + rd_tab[1]);
      chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_rv));
      if (mem_req_valid)
        chk("mem_req_addr", 64'(mem_req_addr), 64'(m_addr[(m_nreq == 2 && rel >= m_s[1]) ? 1 : 0]));
      chk("miss_ready", 64'(miss_ready), 64'(rel > m_tend || rel == 0));
      chk("refill_valid", 64'(refill_valid), 64'(rel == m_tend && m_kind == 1));
      chk("fault_valid", 64'(fault_valid), 64'(rel == m_tend && m_kind == 2));
      if (refill_valid) begin
        n_ref++;
        c_rel = rel;
        c_ppn = refill_ppn;
        c_flags = refill_flags;
        c_level = refill_level;
        c_vpn = refill_vpn;
        c_asid = refill_asid;
        chk("refill_vpn", 64'(refill_vpn), 64'(m_vaddr >> 12));
        chk("refill_ppn", 64'(refill_ppn), 64'(m_ppn));
        chk("refill_flags", 64'(refill_flags), 64'(m_flags));
        chk("refill_level", 64'(refill_level), 64'(m_level));
        chk("refill_asid", 64'(refill_asid), 64'(m_asid));
      end
      if (fault_valid) begin
        n_flt++;
        c_rel = rel;
        c_fva = fault_vaddr;
        chk("fault_vaddr", 64'(fault_vaddr), 64'(m_vaddr));
      end
      if (rel >= m_tend + 4) active = 0;
    end
  end

  task automatic run(input logic [31:0] va, input logic [8:0] asid, input logic [21:0] satp,
                     input logic [31:0] p1, input logic [31:0] p0,
                     input int rd0, input int rd1, input int rs0, input int rs1, input int mode);
    @(negedge clk);
    pte_tab[0] = p1;
    pte_tab[1] = p0;
    rd_tab[0] = rd0;
    rd_tab[1] = rd1;
    rs_tab[0] = rs0;
    rs_tab[1] = rs1;
    ri = 0;
    wc = 0;
    pend = 0;
    m_vaddr = va;
    m_asid = asid;
    model(satp, va, mode);
    n_ref = 0;
    n_flt = 0;
    c_rel = -1;
    miss_vaddr = va;
    miss_asid = asid;
    satp_ppn = satp;
    miss_valid = 1;
    t0 = cyc;
    active = 1;
    for (int r = 1; r <= m_tend + 4; r++) begin
      @(negedge clk);
      miss_valid = 0;
      flush = mode == 1 && r == m_fl;
      rst = mode == 2 && r == m_tend;
    end
    @(negedge clk);
    flush = 0;
    rst = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_miss_ready", 64'(miss_ready), 64'(1));
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_refill_valid", 64'(refill_valid), 64'(0));
    chk("rst_fault_valid", 64'(fault_valid), 64'(0));
    chk("rst_mem_req_addr", 64'(mem_req_addr), 64'(0));
    chk("rst_refill_ppn", 64'(refill_ppn), 64'(0));
    chk("rst_fault_vaddr", 64'(fault_vaddr), 64'(0));
    rst = 0;

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0002_4001, 32'h048D_14C7, 0, 0, 1, 1, 0);
    chk("4k_model_l1_addr", 64'(m_addr[0]), 64'(34'h0_0008_0004));
    chk("4k_model_l0_addr", 64'(m_addr[1]), 64'(34'h0_0009_000C));
    chk("4k_ppn", 64'(c_ppn), 64'(22'h12345));
    chk("4k_flags", 64'(c_flags), 64'(8'hC7));
    chk("4k_level", 64'(c_level), 64'(0));
    chk("4k_vpn", 64'(c_vpn), 64'(20'h00403));
    chk("4k_asid", 64'(c_asid), 64'(9'h005));
    chk("4k_cycle", 64'(c_rel), 64'(5));
    chk("4k_refills", 64'(n_ref), 64'(1));
    chk("4k_faults", 64'(n_flt), 64'(0));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0010_0049, 32'h0, 0, 0, 1, 1, 0);
    chk("super_ppn", 64'(c_ppn), 64'(22'h00400));
    chk("super_flags", 64'(c_flags), 64'(8'h49));
    chk("super_level", 64'(c_level), 64'(1));
    chk("super_cycle", 64'(c_rel), 64'(3));
    chk("super_nreq", 64'(m_nreq), 64'(1));
    chk("super_refills", 64'(n_ref), 64'(1));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0010_0449, 32'h0, 0, 0, 1, 1, 0);
    chk("misalign_faults", 64'(n_flt), 64'(1));
    chk("misalign_refills", 64'(n_ref), 64'(0));
    chk("misalign_vaddr", 64'(c_fva), 64'(32'h0040_3123));
    chk("misalign_cycle", 64'(c_rel), 64'(3));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0000_0000, 32'h0, 0, 0, 1, 1, 0);
    chk("invalid_faults", 64'(n_flt), 64'(1));
    chk("invalid_refills", 64'(n_ref), 64'(0));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0002_4001, 32'h048D_1487, 0, 0, 1, 1, 0);
    chk("a0_faults", 64'(n_flt), 64'(1));
    chk("a0_refills", 64'(n_ref), 64'(0));
    chk("a0_cycle", 64'(c_rel), 64'(5));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0000_0005, 32'h0, 0, 0, 1, 1, 0);
    chk("wonly_faults", 64'(n_flt), 64'(1));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0002_4001, 32'h0000_0001, 0, 0, 1, 1, 0);
    chk("l0_ptr_faults", 64'(n_flt), 64'(1));
    chk("l0_ptr_cycle", 64'(c_rel), 64'(5));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0002_4001, 32'h048D_14C7, 4, 0, 1, 1, 0);
    chk("bp_cycle", 64'(c_rel), 64'(9));
    chk("bp_refills", 64'(n_ref), 64'(1));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0002_4001, 32'h048D_14C7, 0, 0, 1, 3, 1);
    chk("flush_model_tend", 64'(m_tend), 64'(6));
    chk("flush_refills", 64'(n_ref), 64'(0));
    chk("flush_faults", 64'(n_flt), 64'(0));

    run(32'hFFC0_1ABC, 9'h1FF, 22'h3FFFFF, 32'h0000_0401, 32'hFFFF_FCFF, 0, 0, 1, 1, 0);
    chk("max_model_l1_addr", 64'(m_addr[0]), 64'(34'h3_FFFF_FFFC));
    chk("max_model_l0_addr", 64'(m_addr[1]), 64'(34'h0_0000_1004));
    chk("max_ppn", 64'(c_ppn), 64'(22'h3FFFFF));
    chk("max_flags", 64'(c_flags), 64'(8'hFF));
    chk("max_vpn", 64'(c_vpn), 64'(20'hFFC01));
    chk("max_asid", 64'(c_asid), 64'(9'h1FF));
    chk("max_cycle", 64'(c_rel), 64'(5));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0002_4001, 32'h048D_14C7, 0, 0, 3, 1, 2);
    chk("rst_walk_refills", 64'(n_ref), 64'(0));
    chk("rst_walk_faults", 64'(n_flt), 64'(0));
    chk("rst_walk_miss_ready", 64'(miss_ready), 64'(1));
    chk("rst_walk_addr", 64'(mem_req_addr), 64'(0));

    run(32'h0040_3123, 9'h005, 22'h00080, 32'h0010_0049, 32'h0, 0, 0, 1, 1, 0);
    chk("post_rst_cycle", 64'(c_rel), 64'(3));
    chk("post_rst_ppn", 64'(c_ppn), 64'(22'h00400));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
